// File: rtl/rx_ctrl_pkg.sv
// rtl/rx_ctrl_pkg.sv - shared types and helpers for the UART receive controller
// Contents: rx_ctrl_state_t FSM encoding, data_size bounds, data_size clamp and
// data-width mask helper functions.
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2,
        STALL   = 2'd3
    } rx_ctrl_state_t;

    localparam logic [3:0] DATA_SIZE_MIN = 4'd5;
    localparam logic [3:0] DATA_SIZE_MAX = 4'd8;

    // Unsupported frame sizes fall back to a full byte.
    function automatic logic [3:0] clamp_data_size(input logic [3:0] size);
        if ((size < DATA_SIZE_MIN) || (size > DATA_SIZE_MAX)) begin
            return DATA_SIZE_MAX;
        end
        return size;
    endfunction

    // Zero every bit at or above the configured frame size.
    function automatic logic [7:0] mask_data(input logic [7:0] data, input logic [3:0] size);
        logic [7:0] masked;
        masked = '0;
        for (int i = 0; i < 8; i++) begin
            masked[i] = (4'(i) < size) ? data[i] : 1'b0;
        end
        return masked;
    endfunction

endpackage

// File: rtl/rx_ctrl_fifo.sv
// rtl/rx_ctrl_fifo.sv - synchronous FIFO holding received bytes
// Ports: clk, rst (sync active-high), push/wdata write side, pop read side,
// rdata registered head entry, full/empty flags, count occupancy.
// Push while full and pop while empty are ignored.
module rx_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are power-of-two wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - UART receiver sequencing controller (buffer drain, config, error counters)
// Ports: clk, n_rst (sync active-high reset); cfg_wr/cfg_bit_period/cfg_data_size
// config write, cfg_busy; bit_period/data_size to receiver; rx_data/data_ready/
// overrun_error/framing_error from receiver, data_read handshake back; out_data/
// out_valid/out_ready consumer stream; fifo_count; ferr_count/oerr_count saturating
// counters with err_clear.
// Optional macro RX_CTRL_FERR_TAG_EN: keep framing-error bytes, tagged via out_ferr.
module rx_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [13:0] BIT_PERIOD_RST = 14'd10,
    parameter logic [3:0]  DATA_SIZE_RST  = 4'd8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          cfg_wr,
    input  logic [13:0]                   cfg_bit_period,
    input  logic [3:0]                    cfg_data_size,
    output logic                          cfg_busy,
    output logic [13:0]                   bit_period,
    output logic [3:0]                    data_size,
    input  logic [7:0]                    rx_data,
    input  logic                          data_ready,
    input  logic                          overrun_error,
    input  logic                          framing_error,
    output logic                          data_read,
    output logic [7:0]                    out_data,
`ifdef RX_CTRL_FERR_TAG_EN
    output logic                          out_ferr,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    ferr_count,
    output logic [7:0]                    oerr_count,
    input  logic                          err_clear
);

`ifdef RX_CTRL_FERR_TAG_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    rx_ctrl_state_t state_q;
    rx_ctrl_state_t state_d;

    logic          data_read_q;
    logic          ovr_q;
    logic          capture;
    logic [7:0]    masked;
    logic          push;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          ferr_inc;
    logic          oerr_inc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (data_ready) begin
                    state_d = fifo_full ? STALL : CAPTURE;
                end
            end
            CAPTURE: state_d = ACK;
            ACK: begin
                if (!data_ready) begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (!fifo_full) begin
                    state_d = CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // data_read is a flop that mirrors "now in CAPTURE", so it is glitch-free.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            data_read_q <= 1'b0;
        end else begin
            data_read_q <= (state_d == CAPTURE);
        end
    end

    assign data_read = data_read_q;
    assign capture   = (state_q == CAPTURE);
    assign masked    = mask_data(rx_data, data_size);
    assign ferr_inc  = capture & framing_error;

`ifdef RX_CTRL_FERR_TAG_EN
    assign push       = capture;
    assign push_entry = {framing_error, masked};
    assign out_ferr   = head[8];
`else
    assign push       = capture & ~framing_error;
    assign push_entry = masked;
`endif

    // ---------------- FIFO ----------------
    assign pop       = ~fifo_empty & out_ready;
    assign out_valid = ~fifo_empty;
    assign out_data  = head[7:0];

    rx_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (n_rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- Config ----------------
    assign cfg_busy = (state_q != IDLE) | data_ready;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            bit_period <= BIT_PERIOD_RST;
            data_size  <= DATA_SIZE_RST;
        end else if (cfg_wr && !cfg_busy) begin
            bit_period <= cfg_bit_period;
            data_size  <= clamp_data_size(cfg_data_size);
        end
    end

    // ---------------- Error counters ----------------
    // Overrun is a level flag from the receiver; count each assertion once.
    assign oerr_inc = overrun_error & ~ovr_q;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= overrun_error;
        end
    end

    // Clear takes priority over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (n_rst || err_clear) begin
            ferr_count <= '0;
            oerr_count <= '0;
        end else begin
            if (ferr_inc && (ferr_count != 8'hFF)) begin
                ferr_count <= ferr_count + 8'd1;
            end
            if (oerr_inc && (oerr_count != 8'hFF)) begin
                oerr_count <= oerr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - directed self-checking bench for rx_ctrl
module tb_rx_ctrl;
    import rx_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_wr;
    logic [13:0] cfg_bit_period;
    logic [3:0]  cfg_data_size;
    logic        cfg_busy;
    logic [13:0] bit_period;
    logic [3:0]  data_size;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;
    logic        data_read;
    logic [7:0]  out_data;
`ifdef RX_CTRL_FERR_TAG_EN
    logic        out_ferr;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_count;
    logic [7:0]  ferr_count;
    logic [7:0]  oerr_count;
    logic        err_clear;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rx_ctrl dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .cfg_wr         (cfg_wr),
        .cfg_bit_period (cfg_bit_period),
        .cfg_data_size  (cfg_data_size),
        .cfg_busy       (cfg_busy),
        .bit_period     (bit_period),
        .data_size      (data_size),
        .rx_data        (rx_data),
        .data_ready     (data_ready),
        .overrun_error  (overrun_error),
        .framing_error  (framing_error),
        .data_read      (data_read),
        .out_data       (out_data),
`ifdef RX_CTRL_FERR_TAG_EN
        .out_ferr       (out_ferr),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .ferr_count     (ferr_count),
        .oerr_count     (oerr_count),
        .err_clear      (err_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Receiver model: present a byte, wait for data_read, hold through the
    // capture edge, then withdraw data_ready so the controller returns to IDLE.
    task automatic send_byte(input logic [7:0] d, input logic fe);
        int n;
        rx_data       = d;
        framing_error = fe;
        data_ready    = 1'b1;
        n = 0;
        tick();
        while ((data_read !== 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
        check("send_handshake", 32'(data_read), 32'd1);
        tick();
        data_ready    = 1'b0;
        framing_error = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b1; cfg_wr = 1'b0; cfg_bit_period = '0; cfg_data_size = '0;
        rx_data = '0; data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
        out_ready = 1'b0; err_clear = 1'b0;
        tick(); tick();
        n_rst = 1'b0;

        // Reset state
        check("rst_bit_period", 32'(bit_period), 32'd10);
        check("rst_data_size",  32'(data_size),  32'd8);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_ferr",       32'(ferr_count), 32'd0);
        check("rst_oerr",       32'(oerr_count), 32'd0);
        check("rst_data_read",  32'(data_read),  32'd0);
        check("rst_cfg_busy",   32'(cfg_busy),   32'd0);

        // Config write while idle
        cfg_wr = 1'b1; cfg_bit_period = 14'd100; cfg_data_size = 4'd7;
        tick();
        cfg_wr = 1'b0;
        check("cfg_bit_period", 32'(bit_period), 32'd100);
        check("cfg_data_size",  32'(data_size),  32'd7);

        // Byte arrival with a concurrent (ignored) config write
        rx_data = 8'hFF; data_ready = 1'b1;
        cfg_wr = 1'b1; cfg_bit_period = 14'd200; cfg_data_size = 4'd5;
        #1;
        check("busy_on_ready", 32'(cfg_busy), 32'd1);
        tick();
        cfg_wr = 1'b0;
        check("cap_data_read",     32'(data_read),  32'd1);
        check("ign_cfg_bit_period", 32'(bit_period), 32'd100);
        check("ign_cfg_data_size",  32'(data_size),  32'd7);
        check("cap_not_valid_yet",  32'(out_valid),  32'd0);
        tick();
        check("ack_data_read_low", 32'(data_read),  32'd0);
        check("mask_out_valid",    32'(out_valid),  32'd1);
        check("mask_out_data",     32'(out_data),   32'h7F);
        check("mask_fifo_count",   32'(fifo_count), 32'd1);
        data_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_fifo_count", 32'(fifo_count), 32'd0);
        check("pop_out_valid",  32'(out_valid),  32'd0);

        // Out-of-range data_size clamps to 8
        cfg_wr = 1'b1; cfg_bit_period = 14'd100; cfg_data_size = 4'd3;
        tick();
        cfg_wr = 1'b0;
        check("clamp_data_size", 32'(data_size), 32'd8);

        // Fill FIFO, then a 9th byte stalls
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("full_fifo_count", 32'(fifo_count), 32'd8);
        rx_data = 8'h09; data_ready = 1'b1;
        tick();
        check("stall_state",     32'(dut.state_q), 32'(STALL));
        check("stall_no_read_a", 32'(data_read),   32'd0);
        tick();
        check("stall_no_read_b", 32'(data_read),   32'd0);
        check("stall_head",      32'(out_data),    32'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_pop_count", 32'(fifo_count), 32'd7);
        check("stall_no_read_c", 32'(data_read),  32'd0);
        tick();
        check("unstall_read",    32'(data_read),  32'd1);
        tick();
        check("unstall_count",   32'(fifo_count), 32'd8);
        data_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 32'(out_data), 32'(i + 2));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("drain_empty", 32'(fifo_count), 32'd0);

        // Framing error byte
        send_byte(8'hA5, 1'b1);
        check("ferr_count_1", 32'(ferr_count), 32'd1);
`ifdef RX_CTRL_FERR_TAG_EN
        check("ferr_tag_count", 32'(fifo_count), 32'd1);
        check("ferr_tag_data",  32'(out_data),   32'hA5);
        check("ferr_tag_flag",  32'(out_ferr),   32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`else
        check("ferr_drop_count", 32'(fifo_count), 32'd0);
`endif

        // Overrun held 5 cycles counts once
        overrun_error = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        overrun_error = 1'b0;
        tick();
        check("oerr_once", 32'(oerr_count), 32'd1);

        // Framing counter saturates
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h3C, 1'b1);
        end
        check("ferr_saturate", 32'(ferr_count), 32'd255);

        // Clear wins over a simultaneous increment
        overrun_error = 1'b1; err_clear = 1'b1;
        tick();
        check("clr_oerr", 32'(oerr_count), 32'd0);
        check("clr_ferr", 32'(ferr_count), 32'd0);
        send_byte(8'h11, 1'b1);
        err_clear = 1'b0; overrun_error = 1'b0;
        check("clr_ferr_during_inc", 32'(ferr_count), 32'd0);
        tick();
        send_byte(8'h22, 1'b1);
        check("ferr_resume", 32'(ferr_count), 32'd1);
        overrun_error = 1'b1;
        tick();
        overrun_error = 1'b0;
        tick();
        check("oerr_resume", 32'(oerr_count), 32'd1);
        out_ready = 1'b0;
        tick();

        // Reset during ACK with 3 entries
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        rx_data = 8'h33; data_ready = 1'b1;
        tick();
        tick();
        check("pre_rst_state", 32'(dut.state_q), 32'(ACK));
        check("pre_rst_count", 32'(fifo_count),  32'd3);
        n_rst = 1'b1;
        tick();
        n_rst = 1'b0; data_ready = 1'b0;
        check("mid_rst_state",      32'(dut.state_q), 32'(IDLE));
        check("mid_rst_count",      32'(fifo_count),  32'd0);
        check("mid_rst_valid",      32'(out_valid),   32'd0);
        check("mid_rst_ferr",       32'(ferr_count),  32'd0);
        check("mid_rst_oerr",       32'(oerr_count),  32'd0);
        check("mid_rst_bit_period", 32'(bit_period),  32'd10);
        check("mid_rst_data_size",  32'(data_size),   32'd8);
        check("mid_rst_data_read",  32'(data_read),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
Sequencing controller for the UART receiver block. Drains the receiver's single-byte buffer into a local FIFO with a proper data_read handshake, and programs the receiver's bit_period/data_size. Keeps saturating framing and overrun error counters. Sits between the receiver and the downstream consumer or bus-register layer.

Parameters:
FIFO_DEPTH, 8, number of FIFO entries; power of 2, minimum 2.
BIT_PERIOD_RST, 14'd10, bit_period value after reset.
DATA_SIZE_RST, 4'd8, data_size value after reset.

Ports:
clk  in  1  system clock
n_rst  in  1  reset; synchronous, active-high (asserted = 1)
cfg_wr  in  1  config write strobe
cfg_bit_period  in  14  new bit period
cfg_data_size  in  4  new data size
cfg_busy  out  1  config write not accepted this cycle
bit_period  out  14  to receiver
data_size  out  4  to receiver
rx_data  in  8  from receiver buffer
data_ready  in  1  receiver buffer holds a byte
overrun_error  in  1  receiver overrun flag
framing_error  in  1  receiver framing flag for the current byte
data_read  out  1  one-cycle pulse; receiver buffer consumed
out_data  out  8  FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
ferr_count  out  8  saturating framing-error count
oerr_count  out  8  saturating overrun count
err_clear  in  1  clear both counters

Behaviour:
- Reset values: state IDLE; data_read=0; out_valid=0; fifo_count=0; ferr_count=0; oerr_count=0; bit_period=BIT_PERIOD_RST; data_size=DATA_SIZE_RST; cfg_busy=0. FIFO pointers are zeroed. A reset mid-transfer discards FIFO contents and any in-flight byte.
- FSM states: IDLE, CAPTURE, ACK, STALL.
- IDLE: if data_ready=1 and the FIFO is not full, go to CAPTURE. If data_ready=1 and the FIFO is full, go to STALL.
- STALL: hold; do not assert data_read. Go to CAPTURE in the first cycle the FIFO is not full.
- CAPTURE (1 cycle): data_read=1 (registered output, high for exactly this cycle). rx_data is masked: bits at index >= data_size are forced to 0. If framing_error=0, push the byte. If framing_error=1, drop the byte and increment ferr_count. Next state ACK.
- ACK: wait for data_ready=0, then go to IDLE. Minimum 1 cycle.
- Latency: data_ready rises at edge N, so CAPTURE and data_read occur in cycle N+1, and out_valid=1 in cycle N+2 when the FIFO was empty.
- FIFO: push and pop may occur in the same cycle; count is unchanged. Pop happens when out_valid & out_ready. No push is possible when full (STALL guarantees this). Pointers wrap modulo FIFO_DEPTH. out_data is registered-head, not fall-through.
- Overrun: oerr_count increments on the 0->1 edge of overrun_error only.
- Counters saturate at 255. If err_clear and an increment occur in the same cycle, clear wins and the result is 0.
- Config:
  - cfg_busy = (state != IDLE) | data_ready.
  - A cfg_wr with cfg_busy=0 loads both registers at the next edge.
  - A cfg_wr with cfg_busy=1 is ignored (no queuing).
  - cfg_data_size outside 5..8 is clamped to 8.

Optional Feature:
Macro RX_CTRL_FERR_TAG_EN.
- Defined: FIFO entries are 9 bits wide and an extra output out_ferr (1 bit) accompanies out_data. Framing-error bytes are pushed with out_ferr=1 instead of being dropped. ferr_count still increments.
- Undefined: the port is absent, FIFO entries are 8 bits, and framing-error bytes are dropped as described above.

Decomposition:
- Package rx_ctrl_pkg holds:
  - enum rx_ctrl_state_t {IDLE, CAPTURE, ACK, STALL}
  - localparams DATA_SIZE_MIN=5 and DATA_SIZE_MAX=8
  - function for data_size clamp
  - function for the mask
- One sub-module: rx_ctrl_fifo (synchronous FIFO; DEPTH and WIDTH parameters; push/pop/full/empty/count). Instantiated once.

Test Plan:
- Reset, then cfg_wr with bit_period=14'd100 and data_size=4'd7 while idle -> outputs update the next cycle. A second cfg_wr while data_ready=1 is ignored.
- data_size=7, rx_data=8'hFF, data_ready pulse -> data_read high exactly 1 cycle, one cycle after data_ready. out_data=8'h7F and out_valid follow one cycle later.
- out_ready=0 and 9 bytes arrive with FIFO_DEPTH=8 -> fifo_count=8, FSM in STALL, no data_read for the 9th byte. Raising out_ready for 1 cycle gives 1 pop, then the 9th byte is captured, with no loss and original order preserved.
- framing_error=1 with byte 8'hA5 -> fifo_count unchanged and ferr_count=1. With RX_CTRL_FERR_TAG_EN the byte is pushed with out_ferr=1 instead.
- overrun_error held high for 5 cycles -> oerr_count=1. 300 framing errors -> ferr_count=255. err_clear coinciding with an increment -> 0.
- Reset asserted during ACK with 3 FIFO entries -> next cycle: IDLE, fifo_count=0, counters 0, config at its reset defaults.
